// File: rtl/lcd_cmd_sched.sv
// Command scheduler for the LCD image controller: buffers host commands in a FIFO and
// issues them one per slot once the controller is idle, tracking write-out to completion.
module lcd_cmd_sched #(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned AW         = 3,
   parameter int unsigned GAP        = 2,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic          clk_i,
   input  logic          reset_ni,
   input  logic [2:0]    host_cmd_i,
   input  logic          host_valid_i,
   output logic          host_ready_o,
   input  logic          lcd_busy_i,
   input  logic          lcd_done_i,
   output logic [2:0]    cmd_o,
   output logic          cmd_valid_o,
   output logic [AW:0]   pending_o,
   output logic          finished_o,
   output logic          err_timeout_o
);

   localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

   typedef enum logic [2:0] {
      S_LOAD,
      S_READY,
      S_HOLD,
      S_WAIT_WR,
      S_DONE,
      S_ERROR
   } state_t;

   state_t        state_q, state_d;
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic          full_q, full_d;
   logic          empty_q, empty_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [7:0]    timer_q, timer_d;
   logic          wr_seen_q, wr_seen_d;
   logic          last_wr_q, last_wr_d;
   logic [2:0]    cmd_q, cmd_d;
   logic          cmd_valid_q, cmd_valid_d;
   logic          finished_q, finished_d;
   logic          err_q, err_d;
   logic [2:0]    mem_q [FIFO_DEPTH];
   logic          push, pop;
   logic [2:0]    head;

   assign head = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      gap_d       = gap_q;
      timer_d     = timer_q;
      wr_seen_d   = wr_seen_q;
      last_wr_d   = last_wr_q;
      cmd_d       = cmd_q;
      cmd_valid_d = 1'b0;
      finished_d  = finished_q;
      err_d       = err_q;
      pop         = 1'b0;

      host_ready_o = !full_q && !wr_seen_q && (state_q != S_DONE) && (state_q != S_ERROR);
      push         = host_valid_i && host_ready_o;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
         if (host_cmd_i == 3'd0) wr_seen_d = 1'b1;
      end

      unique case (state_q)
         S_LOAD: begin
            if (!lcd_busy_i) begin
               state_d = S_READY;
               timer_d = '0;
            end else if (timer_q == 8'(TIMEOUT)) begin
               state_d = S_ERROR;
               err_d   = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_READY: begin
            if (!empty_q && !lcd_busy_i) begin
               pop         = 1'b1;
               cmd_d       = head;
               cmd_valid_d = 1'b1;
               last_wr_d   = (head == 3'd0);
               gap_d       = '0;
               state_d     = S_HOLD;
            end
         end
         S_HOLD: begin
            if (gap_q == GW'(GAP - 1)) begin
               state_d = last_wr_q ? S_WAIT_WR : S_READY;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         S_WAIT_WR: begin
            // Completion wins over timeout when both land in the same cycle.
            if (lcd_done_i) begin
               state_d    = S_DONE;
               finished_d = 1'b1;
            end else if (timer_q == 8'(TIMEOUT)) begin
               state_d = S_ERROR;
               err_d   = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_DONE:  ;
         S_ERROR: ;
         default: state_d = S_ERROR;
      endcase

      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

      full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
      empty_d = (wr_ptr_d == rd_ptr_d);
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q     <= S_LOAD;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         gap_q       <= '0;
         timer_q     <= '0;
         wr_seen_q   <= 1'b0;
         last_wr_q   <= 1'b0;
         cmd_q       <= '0;
         cmd_valid_q <= 1'b0;
         finished_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         full_q      <= full_d;
         empty_q     <= empty_d;
         gap_q       <= gap_d;
         timer_q     <= timer_d;
         wr_seen_q   <= wr_seen_d;
         last_wr_q   <= last_wr_d;
         cmd_q       <= cmd_d;
         cmd_valid_q <= cmd_valid_d;
         finished_q  <= finished_d;
         err_q       <= err_d;
      end
   end

   // Storage needs no reset: entries are only read between the pointers.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= host_cmd_i;
   end

   assign cmd_o         = cmd_q;
   assign cmd_valid_o   = cmd_valid_q;
   assign pending_o     = wr_ptr_q - rd_ptr_q;
   assign finished_o    = finished_q;
   assign err_timeout_o = err_q;

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Self-checking bench for lcd_cmd_sched: scoreboard on issued commands plus
// table-driven FIFO fill and hand-written multi-cycle sequences.
module tb_lcd_cmd_sched;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [2:0] host_cmd;
   logic       host_valid;
   logic       host_ready;
   logic       lcd_busy;
   logic       lcd_done;
   logic [2:0] cmd;
   logic       cmd_valid;
   logic [3:0] pending;
   logic       finished;
   logic       err_timeout;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [2:0] sb[$];
   int issue_cyc[$];

   typedef struct {
      logic       v;
      logic [2:0] code;
      logic       exp_ready;
      logic [3:0] exp_pend;
   } vec_t;
   vec_t tbl[9];

   lcd_cmd_sched #(.FIFO_DEPTH(8), .AW(3), .GAP(2), .TIMEOUT(255)) dut (
      .clk_i(clk), .reset_ni(reset_n), .host_cmd_i(host_cmd), .host_valid_i(host_valid),
      .host_ready_o(host_ready), .lcd_busy_i(lcd_busy), .lcd_done_i(lcd_done),
      .cmd_o(cmd), .cmd_valid_o(cmd_valid), .pending_o(pending),
      .finished_o(finished), .err_timeout_o(err_timeout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (reset_n === 1'b1 && cmd_valid === 1'b1) begin
         logic [2:0] e;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_issue: got cmd %0d expected no issue", cmd);
         end else begin
            e = sb.pop_front();
            if (cmd !== e) begin
               errors++;
               $display("FAIL issue_order: got cmd %0d expected %0d", cmd, e);
            end
         end
         issue_cyc.push_back(cyc);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic busy);
      reset_n    = 1'b0;
      host_valid = 1'b0;
      host_cmd   = 3'd0;
      lcd_done   = 1'b0;
      lcd_busy   = busy;
      sb.delete();
      issue_cyc.delete();
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic push_cmd(input logic [2:0] c, input string nm);
      host_cmd   = c;
      host_valid = 1'b1;
      chk(nm, host_ready, 1);
      sb.push_back(c);
      tick();
      host_valid = 1'b0;
   endtask

   task automatic drain(input int maxc, input string nm);
      int k = 0;
      while (sb.size() != 0 && k < maxc) begin
         tick();
         k++;
      end
      chk(nm, sb.size(), 0);
   endtask

   initial begin
      logic [2:0] codes[8];
      int n;
      codes = '{3'd4, 3'd1, 3'd7, 3'd2, 3'd6, 3'd3, 3'd5, 3'd1};
      for (int i = 0; i < 8; i++) tbl[i] = '{1'b1, codes[i], 1'b1, 4'(i + 1)};
      tbl[8] = '{1'b1, 3'd2, 1'b0, 4'd8};

      // Reset state and basic two-command issue with latency and spacing
      reset_n = 1'b1;
      do_reset(1'b1);
      reset_n = 1'b0;
      #1;
      chk("rst_cmd", cmd, 0);
      chk("rst_cmd_valid", cmd_valid, 0);
      chk("rst_pending", pending, 0);
      chk("rst_finished", finished, 0);
      chk("rst_err", err_timeout, 0);
      chk("rst_ready", host_ready, 1);
      tick();
      reset_n = 1'b1;
      repeat (70) tick();
      chk("load_no_err", err_timeout, 0);
      lcd_busy = 1'b0;
      tick();
      tick();
      host_cmd = 3'd3; host_valid = 1'b1; sb.push_back(3'd3);
      tick();
      chk("lat_edge_n", cmd_valid, 0);
      chk("lat_pend_n", pending, 1);
      host_cmd = 3'd5; sb.push_back(3'd5);
      tick();
      host_valid = 1'b0;
      chk("lat_edge_n1", cmd_valid, 1);
      chk("lat_cmd", cmd, 3);
      chk("pushpop_pend", pending, 1);
      drain(20, "t1_drain");
      tick();
      chk("t1_issues", issue_cyc.size(), 2);
      if (issue_cyc.size() == 2) chk("t1_spacing", issue_cyc[1] - issue_cyc[0], 3);
      chk("t1_pend_end", pending, 0);

      // Fill to full while busy, blocked push, then in-order drain
      lcd_busy = 1'b1;
      tick();
      for (int i = 0; i < 9; i++) begin
         host_valid = tbl[i].v;
         host_cmd   = tbl[i].code;
         chk($sformatf("fill_ready_%0d", i), host_ready, tbl[i].exp_ready);
         if (tbl[i].v && tbl[i].exp_ready) sb.push_back(tbl[i].code);
         tick();
         chk($sformatf("fill_pend_%0d", i), pending, tbl[i].exp_pend);
      end
      host_valid = 1'b0;
      chk("full_ready", host_ready, 0);
      lcd_busy = 1'b0;
      drain(60, "t2_drain");
      repeat (4) tick();
      chk("t2_pend_end", pending, 0);

      // Push while popping at pending=4; lcd_done in READY ignored
      lcd_busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         codes[0] = 3'(2 * i + 1);
         push_cmd(codes[0], $sformatf("t6_push_%0d", i));
      end
      chk("t6_pend4", pending, 4);
      lcd_done = 1'b1;
      tick();
      lcd_done = 1'b0;
      chk("done_ignored", finished, 0);
      lcd_busy = 1'b0; host_cmd = 3'd6; host_valid = 1'b1; sb.push_back(3'd6);
      tick();
      host_valid = 1'b0;
      chk("t6_pend_stay", pending, 4);
      chk("t6_issue", cmd_valid, 1);
      drain(40, "t6_drain");
      chk("t6_not_fin", finished, 0);

      // Write-out: 1, 0, then 2 rejected; done completes
      do_reset(1'b0);
      tick(); tick();
      lcd_busy = 1'b1;
      tick();
      push_cmd(3'd1, "t3_push1");
      push_cmd(3'd0, "t3_push0");
      host_cmd = 3'd2; host_valid = 1'b1;
      chk("t3_reject", host_ready, 0);
      tick();
      host_valid = 1'b0;
      chk("t3_pend", pending, 2);
      lcd_busy = 1'b0;
      drain(40, "t3_drain");
      repeat (6) tick();
      chk("t3_wait_fin", finished, 0);
      lcd_done = 1'b1;
      tick();
      lcd_done = 1'b0;
      chk("t3_finished", finished, 1);
      chk("t3_done_ready", host_ready, 0);
      repeat (10) tick();
      chk("t3_issue_cnt", issue_cyc.size(), 2);
      chk("t3_fin_sticky", finished, 1);

      // Timeout in LOAD
      do_reset(1'b1);
      n = 0;
      while (err_timeout !== 1'b1 && n < 400) begin
         tick();
         n++;
      end
      chk("load_to_cycles", n, 256);
      chk("load_to_ready", host_ready, 0);
      chk("load_to_valid", cmd_valid, 0);

      // Timeout in WAIT_WR
      do_reset(1'b0);
      tick(); tick();
      push_cmd(3'd0, "t4_push0");
      n = 0;
      while (err_timeout !== 1'b1 && n < 400) begin
         tick();
         n++;
      end
      chk("wr_to_cycles", n, 259);
      chk("wr_to_fin", finished, 0);
      chk("wr_to_ready", host_ready, 0);

      // Reset during HOLD with entries pending
      do_reset(1'b0);
      tick(); tick();
      lcd_busy = 1'b1;
      for (int i = 1; i <= 5; i++) push_cmd(3'(i), $sformatf("t5_push_%0d", i));
      lcd_busy = 1'b0;
      tick();
      chk("t5_issue", cmd_valid, 1);
      chk("t5_cmd", cmd, 1);
      chk("t5_pend4", pending, 4);
      sb.delete();
      #1 reset_n = 1'b0;
      #1;
      chk("t5_rst_pend", pending, 0);
      chk("t5_rst_valid", cmd_valid, 0);
      chk("t5_rst_cmd", cmd, 0);
      chk("t5_rst_ready", host_ready, 1);
      tick();
      reset_n = 1'b1;
      issue_cyc.delete();
      tick(); tick();
      push_cmd(3'd6, "t5_after_push");
      drain(20, "t5_after_drain");
      chk("t5_after_issues", issue_cyc.size(), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
